trap_ctrl: RTL and testbench
============================

# trap_ctrl

Parametrised machine-mode trap controller for the RV64 pipeline. It arbitrates synchronous exceptions from N pipeline stages, the software, timer and external interrupts, and MRET. It issues a one-cycle redirect to the fetch/ctrl logic and sequences the mepc, mcause, mtval and mstatus writes into csr_reg, one per cycle. Compared with the single-cause interrupt block, it adds stage count, oldest-first priority, full mcause encoding with the interrupt bit, mtval, vectored mtvec, a busy/stall output and MPP handling.

## Interface
- XLEN, 64, datapath and CSR width
- N_STAGE, 3, exception-reporting stages; index 0 = youngest (IF), N_STAGE-1 = oldest (EX)
- CAUSE_W, 4, exception cause code width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- exc_valid_i  in  N_STAGE  per-stage exception request
- exc_cause_i  in  N_STAGE*CAUSE_W  per-stage cause code; stage k at slice [k*CAUSE_W +: CAUSE_W]
- exc_pc_i  in  N_STAGE*XLEN  per-stage faulting PC
- exc_tval_i  in  N_STAGE*XLEN  per-stage trap value
- mret_i  in  1  MRET decoded in ID
- int_pc_i  in  XLEN  PC of next instruction to retire; becomes mepc for interrupts
- irq_sw_i, irq_tmr_i, irq_ext_i  in  1 each  level interrupt lines
- csr_mstatus, csr_mie, csr_mtvec, csr_mepc  in  XLEN each  current CSR values
- trap_o  out  1  one-cycle redirect pulse
- trap_addr_o  out  XLEN  redirect target, valid with trap_o
- busy_o  out  1  sequence in progress; ctrl stalls the pipeline
- csr_we_o  out  1  CSR write strobe
- csr_addr_o  out  12  CSR address
- csr_data_o  out  XLEN  CSR write data

## Operation
- Interrupt pending: mstatus[3] & ((irq_ext_i & mie[11]) | (irq_sw_i & mie[3]) | (irq_tmr_i & mie[7])).
- Interrupt priority: MEI (code 11) > MSI (3) > MTI (7).
- Event priority in IDLE: any exception > mret_i > interrupt.
- Among exceptions, the highest asserted stage index wins.
- Capture in IDLE registers the event kind, cause, pc, tval and csr_mstatus.
  - Exception: cause = {1'b0, zero-extended code}, pc = exc_pc_i, tval = exc_tval_i.
  - Interrupt: cause = {1'b1, zero, code}, pc = int_pc_i, tval = 0.
- Target for exception or interrupt:
  - Base = {mtvec[XLEN-1:2], 2'b00}.
  - Interrupt with mtvec[1:0]==2'b01: base + 4*code.
  - All other cases, including modes 1x: base.
- Target for MRET: csr_mepc with bit 0 cleared.
- FSM states:
  - IDLE: trap or interrupt -> MEPC; mret -> MRET.
  - MEPC -> MCAUSE -> MTVAL -> MSTATUS -> IDLE.
  - MRET -> IDLE.
  - Illegal encoding -> IDLE.
- CSR write in each state:
  - MEPC: 0x341 <- pc.
  - MCAUSE: 0x342 <- cause.
  - MTVAL: 0x343 <- tval.
  - MSTATUS (trap): 0x300 <- captured mstatus with MPIE[7] = MIE[3], MIE = 0, MPP[12:11] = 2'b11.
  - MRET: 0x300 <- captured mstatus with MIE = MPIE, MPIE = 1, MPP = 2'b11.
- All requests are ignored outside IDLE. Interrupts are level and are re-evaluated on return to IDLE; the pipeline is flushed by trap_o, so exceptions are not lost.

## Timing
- Reset: IDLE; trap_o=0, trap_addr_o=0, busy_o=0, csr_we_o=0, csr_addr_o=0, csr_data_o=0; capture registers 0.
- Reset mid-sequence abandons all remaining writes on the next edge. Partial CSR updates are not rolled back.
- Event sampled in IDLE at cycle T (all outputs registered):
  - T+1: trap_o=1 with trap_addr_o.
  - Trap: mepc write at T+1, mcause at T+2, mtval at T+3, mstatus at T+4. busy_o high T+1..T+4. Next event accepted at T+5.
  - MRET: mstatus write at T+1, busy_o high at T+1 only. Next event accepted at T+2.
- csr_we_o is 0, and csr_addr_o/csr_data_o are 0, in every cycle without a write.
- MIE=0 is visible on csr_mstatus from T+5, so a still-pending interrupt does not re-trap.
- Simultaneous exception + mret + interrupt at T: only the exception is taken.

## Test plan
- Stage 2 exception, cause 2, pc 0x8000_0010, tval 0xDEAD, mtvec 0x8000_0100, mstatus 0x8 -> required response:
  - trap_o at T+1 with addr 0x8000_0100.
  - Writes 0x341=0x8000_0010, 0x342=0x2, 0x343=0xDEAD, 0x300=0x1880.
  - busy_o high 4 cycles.
- Stages 0 and 2 both asserted, causes 1 and 5 -> mcause 0x5, mepc = stage-2 pc.
- Timer and external interrupt both pending, mie 0x880, mstatus 0x8, mtvec 0x8000_0101, int_pc_i 0x8000_0040 -> required response:
  - addr 0x8000_012C.
  - mcause 0x8000_0000_0000_000B, mepc 0x8000_0040, mtval 0.
- mret_i with mstatus 0x1880, mepc 0x8000_0044 -> trap_addr_o 0x8000_0044, single write 0x300=0x1888, busy_o 1 cycle.
- mstatus 0x0 with all interrupts pending -> no trap_o, no CSR writes for 20 cycles. Exception held during busy_o -> no second sequence until IDLE.
- rst_n low at T+2 of a trap sequence -> all outputs 0 at T+3, no mtval or mstatus write, new trap accepted after reset release.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Trap controller bundle: pipeline exception/interrupt requests and current CSR values in,
// redirect pulse, stall and CSR write port out. master = pipeline/CSR side, slave = trap_ctrl.
interface trap_ctrl_if #(
  parameter int XLEN    = 64,
  parameter int N_STAGE = 3,
  parameter int CAUSE_W = 4
);
  logic [N_STAGE-1:0]         exc_valid_i;
  logic [N_STAGE*CAUSE_W-1:0] exc_cause_i;
  logic [N_STAGE*XLEN-1:0]    exc_pc_i;
  logic [N_STAGE*XLEN-1:0]    exc_tval_i;
  logic                       mret_i;
  logic [XLEN-1:0]            int_pc_i;
  logic                       irq_sw_i;
  logic                       irq_tmr_i;
  logic                       irq_ext_i;
  logic [XLEN-1:0]            csr_mstatus;
  logic [XLEN-1:0]            csr_mie;
  logic [XLEN-1:0]            csr_mtvec;
  logic [XLEN-1:0]            csr_mepc;
  logic                       trap_o;
  logic [XLEN-1:0]            trap_addr_o;
  logic                       busy_o;
  logic                       csr_we_o;
  logic [11:0]                csr_addr_o;
  logic [XLEN-1:0]            csr_data_o;

  modport master (
    output exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i, int_pc_i,
           irq_sw_i, irq_tmr_i, irq_ext_i, csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
    input  trap_o, trap_addr_o, busy_o, csr_we_o, csr_addr_o, csr_data_o
  );

  modport slave (
    input  exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i, mret_i, int_pc_i,
           irq_sw_i, irq_tmr_i, irq_ext_i, csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
    output trap_o, trap_addr_o, busy_o, csr_we_o, csr_addr_o, csr_data_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// M-mode trap controller: redirect one cycle after an event accepted in IDLE, then mepc/mcause/
// mtval/mstatus written one per cycle (MRET: one mstatus write); busy_o stalls, requests ignored.
module trap_ctrl #(
  parameter int XLEN    = 64,
  parameter int N_STAGE = 3,
  parameter int CAUSE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  trap_ctrl_if.slave bus
);
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MCAUSE  = 3'd2,
    S_MTVAL   = 3'd3,
    S_MSTATUS = 3'd4,
    S_MRET    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;
  logic            busy_q, busy_d;
  logic            csr_we_q, csr_we_d;
  logic [11:0]     csr_addr_q, csr_addr_d;
  logic [XLEN-1:0] csr_data_q, csr_data_d;

  logic               exc_any;
  logic [CAUSE_W-1:0] exc_code;
  logic [XLEN-1:0]    exc_pc;
  logic [XLEN-1:0]    exc_tval;
  logic               mei, msi, mti, irq_any;
  logic [3:0]         irq_code;
  logic [XLEN-1:0]    tvec_base;
  logic [XLEN-1:0]    irq_target;
  logic               unused_csr_bits;

  function automatic logic [XLEN-1:0] ms_trap(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ms_mret(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Ascending scan: the oldest (highest-index) asserted stage is assigned last and wins.
  always_comb begin
    exc_code = '0;
    exc_pc   = '0;
    exc_tval = '0;
    for (int k = 0; k < N_STAGE; k++) begin
      if (bus.exc_valid_i[k]) begin
        exc_code = bus.exc_cause_i[k*CAUSE_W +: CAUSE_W];
        exc_pc   = bus.exc_pc_i[k*XLEN +: XLEN];
        exc_tval = bus.exc_tval_i[k*XLEN +: XLEN];
      end
    end
  end

  assign exc_any    = |bus.exc_valid_i;
  assign mei        = bus.csr_mstatus[3] & bus.irq_ext_i & bus.csr_mie[11];
  assign msi        = bus.csr_mstatus[3] & bus.irq_sw_i  & bus.csr_mie[3];
  assign mti        = bus.csr_mstatus[3] & bus.irq_tmr_i & bus.csr_mie[7];
  assign irq_any    = mei | msi | mti;
  assign irq_code   = mei ? 4'd11 : (msi ? 4'd3 : 4'd7);
  assign tvec_base  = {bus.csr_mtvec[XLEN-1:2], 2'b00};
  assign irq_target = (bus.csr_mtvec[1:0] == 2'b01) ? tvec_base + (XLEN'(irq_code) << 2)
                                                    : tvec_base;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    pc_d        = pc_q;
    tval_d      = tval_q;
    mstatus_d   = mstatus_q;
    trap_d      = 1'b0;
    trap_addr_d = '0;
    busy_d      = 1'b0;
    csr_we_d    = 1'b0;
    csr_addr_d  = '0;
    csr_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (exc_any || (!bus.mret_i && irq_any)) begin
          state_d     = S_MEPC;
          mstatus_d   = bus.csr_mstatus;
          trap_d      = 1'b1;
          busy_d      = 1'b1;
          csr_we_d    = 1'b1;
          csr_addr_d  = A_MEPC;
          if (exc_any) begin
            cause_d     = XLEN'(exc_code);
            pc_d        = exc_pc;
            tval_d      = exc_tval;
            trap_addr_d = tvec_base;
            csr_data_d  = exc_pc;
          end else begin
            cause_d     = {1'b1, {(XLEN-5){1'b0}}, irq_code};
            pc_d        = bus.int_pc_i;
            tval_d      = '0;
            trap_addr_d = irq_target;
            csr_data_d  = bus.int_pc_i;
          end
        end else if (bus.mret_i) begin
          state_d     = S_MRET;
          mstatus_d   = bus.csr_mstatus;
          trap_d      = 1'b1;
          trap_addr_d = {bus.csr_mepc[XLEN-1:1], 1'b0};
          busy_d      = 1'b1;
          csr_we_d    = 1'b1;
          csr_addr_d  = A_MSTATUS;
          csr_data_d  = ms_mret(bus.csr_mstatus);
        end
      end
      S_MEPC: begin
        state_d    = S_MCAUSE;
        busy_d     = 1'b1;
        csr_we_d   = 1'b1;
        csr_addr_d = A_MCAUSE;
        csr_data_d = cause_q;
      end
      S_MCAUSE: begin
        state_d    = S_MTVAL;
        busy_d     = 1'b1;
        csr_we_d   = 1'b1;
        csr_addr_d = A_MTVAL;
        csr_data_d = tval_q;
      end
      S_MTVAL: begin
        state_d    = S_MSTATUS;
        busy_d     = 1'b1;
        csr_we_d   = 1'b1;
        csr_addr_d = A_MSTATUS;
        csr_data_d = ms_trap(mstatus_q);
      end
      S_MSTATUS: state_d = S_IDLE;
      S_MRET:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cause_q     <= '0;
      pc_q        <= '0;
      tval_q      <= '0;
      mstatus_q   <= '0;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
      busy_q      <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      pc_q        <= pc_d;
      tval_q      <= tval_d;
      mstatus_q   <= mstatus_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
      busy_q      <= busy_d;
      csr_we_q    <= csr_we_d;
      csr_addr_q  <= csr_addr_d;
      csr_data_q  <= csr_data_d;
    end
  end

  assign bus.trap_o      = trap_q;
  assign bus.trap_addr_o = trap_addr_q;
  assign bus.busy_o      = busy_q;
  assign bus.csr_we_o    = csr_we_q;
  assign bus.csr_addr_o  = csr_addr_q;
  assign bus.csr_data_o  = csr_data_q;

  assign unused_csr_bits = ^{bus.csr_mie[XLEN-1:12], bus.csr_mie[10:8], bus.csr_mie[6:4],
                             bus.csr_mie[2:0], bus.csr_mepc[0]};
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus randomized traffic, every cycle compared against
// a queue-of-expected-outputs reference model; the bench also plays the CSR file.
module tb_trap_ctrl;
  localparam int XLEN = 64;
  localparam int NS   = 3;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(XLEN), .N_STAGE(NS), .CAUSE_W(CW)) bus ();
  trap_ctrl #(.XLEN(XLEN), .N_STAGE(NS), .CAUSE_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic        trap;
    logic [63:0] addr;
    logic        busy;
    logic        we;
    logic [11:0] a;
    logic [63:0] d;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] mstatus_r, mie_r, mtvec_r, mepc_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic t, input logic [63:0] ad, input logic b,
                              input logic w, input logic [11:0] a, input logic [63:0] d);
    exp_t e;
    e.trap = t; e.addr = ad; e.busy = b; e.we = w; e.a = a; e.d = d;
    return e;
  endfunction

  function automatic logic [63:0] trap_ms(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1800 | (m[3] ? 64'h80 : 64'h0);
  endfunction

  function automatic logic [63:0] mret_ms(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1880 | (m[7] ? 64'h8 : 64'h0);
  endfunction

  task automatic push_trap(input logic [63:0] tgt, input logic [63:0] pc,
                           input logic [63:0] cause, input logic [63:0] tval);
    exp_q.push_back(mk(1'b1, tgt,   1'b1, 1'b1, 12'h341, pc));
    exp_q.push_back(mk(1'b0, 64'h0, 1'b1, 1'b1, 12'h342, cause));
    exp_q.push_back(mk(1'b0, 64'h0, 1'b1, 1'b1, 12'h343, tval));
    exp_q.push_back(mk(1'b0, 64'h0, 1'b1, 1'b1, 12'h300, trap_ms(mstatus_r)));
    exp_q.push_back('0);
  endtask

  // Decide which event an idle controller takes this cycle and queue the whole response.
  task automatic model_decide();
    int          k_sel = -1;
    int          codes[3];
    logic        lines[3];
    int          code = -1;
    logic [63:0] base;
    codes = '{11, 3, 7};
    lines = '{bus.irq_ext_i, bus.irq_sw_i, bus.irq_tmr_i};
    base  = mtvec_r & ~64'h3;
    for (int k = 0; k < NS; k++) if (bus.exc_valid_i[k]) k_sel = k;
    if (mstatus_r[3])
      for (int i = 2; i >= 0; i--) if (lines[i] && mie_r[codes[i]]) code = codes[i];
    if (k_sel >= 0) begin
      push_trap(base, bus.exc_pc_i[k_sel*64 +: 64],
                64'(bus.exc_cause_i[k_sel*CW +: CW]), bus.exc_tval_i[k_sel*64 +: 64]);
    end else if (bus.mret_i) begin
      exp_q.push_back(mk(1'b1, mepc_r & ~64'h1, 1'b1, 1'b1, 12'h300, mret_ms(mstatus_r)));
      exp_q.push_back('0);
    end else if (code >= 0) begin
      push_trap((mtvec_r[1:0] == 2'b01) ? base + 64'(4 * code) : base, bus.int_pc_i,
                64'h8000_0000_0000_0000 | 64'(code), 64'h0);
    end
  endtask

  task automatic step();
    exp_t e;
    bus.csr_mstatus = mstatus_r;
    bus.csr_mie     = mie_r;
    bus.csr_mtvec   = mtvec_r;
    bus.csr_mepc    = mepc_r;
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() == 0) model_decide();
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    @(posedge clk);
    #1;
    check("trap_o", 64'(bus.trap_o), 64'(e.trap));
    if (e.trap) check("trap_addr", bus.trap_addr_o, e.addr);
    check("busy_o", 64'(bus.busy_o), 64'(e.busy));
    check("csr_we", 64'(bus.csr_we_o), 64'(e.we));
    check("csr_addr", 64'(bus.csr_addr_o), 64'(e.a));
    check("csr_data", bus.csr_data_o, e.d);
    if (e.we && e.a == 12'h300) mstatus_r = e.d;
    if (e.we && e.a == 12'h341) mepc_r = e.d;
  endtask

  task automatic quiet_inputs();
    bus.exc_valid_i = '0;
    bus.exc_cause_i = '0;
    bus.exc_pc_i    = '0;
    bus.exc_tval_i  = '0;
    bus.mret_i      = 1'b0;
    bus.int_pc_i    = '0;
    bus.irq_sw_i    = 1'b0;
    bus.irq_tmr_i   = 1'b0;
    bus.irq_ext_i   = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.exc_valid_i = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
    bus.exc_cause_i = 12'($urandom);
    for (int k = 0; k < NS; k++) begin
      bus.exc_pc_i[k*64 +: 64]   = {$urandom, $urandom};
      bus.exc_tval_i[k*64 +: 64] = {$urandom, $urandom};
    end
    bus.mret_i    = ($urandom_range(0, 5) == 0);
    bus.int_pc_i  = {$urandom, $urandom};
    bus.irq_sw_i  = ($urandom_range(0, 2) == 0);
    bus.irq_tmr_i = ($urandom_range(0, 2) == 0);
    bus.irq_ext_i = ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 7) == 0)  mstatus_r[3] = 1'b1;
    if ($urandom_range(0, 31) == 0) mstatus_r = {$urandom, $urandom};
    if ($urandom_range(0, 15) == 0) mtvec_r = {$urandom, $urandom};
    if ($urandom_range(0, 15) == 0) mie_r = ($urandom_range(0, 1) == 0) ? 64'h888 : {$urandom, $urandom};
    if ($urandom_range(0, 15) == 0) mepc_r = {$urandom, $urandom};
    rst_n = ($urandom_range(0, 99) != 0);
  endtask

  initial begin
    int cnt;
    quiet_inputs();
    mstatus_r = 64'h8;
    mie_r     = 64'h0;
    mtvec_r   = 64'h8000_0100;
    mepc_r    = 64'h0;
    rst_n     = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Stage-2 exception, held through the whole sequence.
    bus.exc_valid_i         = 3'b100;
    bus.exc_cause_i[8 +: 4] = 4'd2;
    bus.exc_pc_i[128 +: 64] = 64'h8000_0010;
    bus.exc_tval_i[128 +: 64] = 64'hDEAD;
    step();
    check("t1_trap", 64'(bus.trap_o), 64'h1);
    check("t1_addr", bus.trap_addr_o, 64'h8000_0100);
    check("t1_mepc", bus.csr_data_o, 64'h8000_0010);
    step();
    check("t1_mcause", bus.csr_data_o, 64'h2);
    step();
    check("t1_mtval", bus.csr_data_o, 64'hDEAD);
    step();
    check("t1_mstatus", bus.csr_data_o, 64'h1880);
    check("t1_busy4", 64'(bus.busy_o), 64'h1);
    step();
    check("t1_idle_busy", 64'(bus.busy_o), 64'h0);
    check("t1_idle_trap", 64'(bus.trap_o), 64'h0);
    quiet_inputs();
    repeat (2) step();

    // Stages 0 and 2 plus mret and interrupt at once: oldest exception only.
    mstatus_r = 64'h8;
    mie_r     = 64'h800;
    bus.irq_ext_i = 1'b1;
    bus.mret_i    = 1'b1;
    bus.exc_valid_i = 3'b101;
    bus.exc_cause_i[0 +: 4] = 4'd1;
    bus.exc_cause_i[8 +: 4] = 4'd5;
    bus.exc_pc_i[0 +: 64]   = 64'h1000;
    bus.exc_pc_i[128 +: 64] = 64'h8000_0020;
    step();
    check("t2_addr", 64'(bus.csr_addr_o), 64'h341);
    check("t2_mepc", bus.csr_data_o, 64'h8000_0020);
    step();
    check("t2_mcause", bus.csr_data_o, 64'h5);
    quiet_inputs();
    repeat (5) step();

    // Timer + external pending, vectored mtvec.
    mstatus_r = 64'h8;
    mie_r     = 64'h880;
    mtvec_r   = 64'h8000_0101;
    bus.int_pc_i  = 64'h8000_0040;
    bus.irq_tmr_i = 1'b1;
    bus.irq_ext_i = 1'b1;
    step();
    check("t3_addr", bus.trap_addr_o, 64'h8000_012C);
    check("t3_mepc", bus.csr_data_o, 64'h8000_0040);
    step();
    check("t3_mcause", bus.csr_data_o, 64'h8000_0000_0000_000B);
    step();
    check("t3_mtval", bus.csr_data_o, 64'h0);
    step();
    cnt = 0;
    repeat (6) begin
      step();
      if (bus.trap_o) cnt++;
    end
    check("t3_no_retrap", 64'(cnt), 64'h0);
    quiet_inputs();

    // MRET.
    mstatus_r  = 64'h1880;
    mepc_r     = 64'h8000_0044;
    bus.mret_i = 1'b1;
    step();
    check("t4_addr", bus.trap_addr_o, 64'h8000_0044);
    check("t4_csr", 64'(bus.csr_addr_o), 64'h300);
    check("t4_mstatus", bus.csr_data_o, 64'h1888);
    bus.mret_i = 1'b0;
    step();
    check("t4_busy1", 64'(bus.busy_o), 64'h0);

    // Global MIE clear masks everything.
    mstatus_r = 64'h0;
    mie_r     = 64'h888;
    bus.irq_sw_i = 1'b1; bus.irq_tmr_i = 1'b1; bus.irq_ext_i = 1'b1;
    cnt = 0;
    repeat (20) begin
      step();
      if (bus.trap_o || bus.csr_we_o) cnt++;
    end
    check("t5_quiet", 64'(cnt), 64'h0);
    quiet_inputs();

    // Reset in the middle of a trap sequence.
    mstatus_r = 64'h8;
    mtvec_r   = 64'h8000_0200;
    bus.exc_valid_i = 3'b010;
    bus.exc_cause_i[4 +: 4] = 4'd7;
    bus.exc_pc_i[64 +: 64]  = 64'h8000_0300;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("t6_rst_trap", 64'(bus.trap_o), 64'h0);
    check("t6_rst_busy", 64'(bus.busy_o), 64'h0);
    check("t6_rst_we", 64'(bus.csr_we_o), 64'h0);
    check("t6_rst_data", bus.csr_data_o, 64'h0);
    rst_n = 1'b1;
    step();
    check("t6_retrap", 64'(bus.trap_o), 64'h1);
    quiet_inputs();
    repeat (5) step();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
